// File: rtl/mchan_trans_arbiter_wq_pkg.sv
// Shared types and constants for the mchan transaction arbiter.
// The packed command layout also sets the default payload width.
package mchan_trans_arbiter_wq_pkg;

    localparam logic MCHAN_ARB_RR = 1'b0;
    localparam logic MCHAN_ARB_FP = 1'b1;

    typedef struct packed {
        logic [1:0]  sid;
        logic [1:0]  twd_tcdm_add;
        logic [1:0]  twd_ext_add;
        logic        twd_tcdm;
        logic        ble;
        logic        ile;
        logic        ele;
        logic        twd_ext;
        logic        inc;
        logic        opc;
        logic [8:0]  len;
        logic [9:0]  tcdm_add;
        logic [31:0] ext_add;
    } mchan_trans_t;

    function automatic int mchan_trans_width();
        return $bits(mchan_trans_t);
    endfunction

endpackage

// File: rtl/mchan_rr_prio_sel.sv
// Rotating priority selector: the first set bit of the eligible vector at or
// after the start pointer wins, wrapping modulo N.
module mchan_rr_prio_sel #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx,
    output logic          any_valid
);

    // Walk from the farthest position back to the pointer so the closest hit wins.
    always_comb begin
        win_oh    = '0;
        win_idx   = '0;
        any_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (elig[(int'(ptr) + k) % N]) begin
                win_oh                       = '0;
                win_oh[(int'(ptr) + k) % N]  = 1'b1;
                win_idx                      = IW'((int'(ptr) + k) % N);
                any_valid                    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mchan_trans_arbiter_wq.sv
// N-channel transaction arbiter with weighted round-robin or fixed priority,
// an enable mask and a registered single-entry output slot.
module mchan_trans_arbiter_wq
    import mchan_trans_arbiter_wq_pkg::*;
#(
    parameter int NB_CTRLS      = 4,
    parameter int PAYLOAD_WIDTH = mchan_trans_width(),
    parameter int QUANTUM_WIDTH = 3,
    parameter int CID_WIDTH     = (NB_CTRLS > 1) ? $clog2(NB_CTRLS) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NB_CTRLS-1:0]                    req_i,
    output logic [NB_CTRLS-1:0]                    gnt_o,
    input  logic [NB_CTRLS-1:0][PAYLOAD_WIDTH-1:0] payload_i,
    input  logic [NB_CTRLS-1:0]                    en_i,
    input  logic                                   mode_i,
    input  logic [NB_CTRLS-1:0][QUANTUM_WIDTH-1:0] quantum_i,
    output logic                                   req_o,
    input  logic                                   gnt_i,
    output logic [PAYLOAD_WIDTH-1:0]               payload_o,
    output logic [CID_WIDTH-1:0]                   cid_o,
    output logic                                   busy_o
);

    logic [NB_CTRLS-1:0]      elig;
    logic                     free;
    logic                     slot_q;
    logic [PAYLOAD_WIDTH-1:0] payload_q;
    logic [CID_WIDTH-1:0]     cid_q;

    logic [CID_WIDTH-1:0]     ptr_q;
    logic [CID_WIDTH-1:0]     owner_q;
    logic [QUANTUM_WIDTH-1:0] cnt_q;
    logic                     owner_v_q;

    logic [QUANTUM_WIDTH-1:0] quantum_sel;
    logic [QUANTUM_WIDTH-1:0] quantum_eff;
    logic                     rr_mode;
    logic                     keep;
    logic [CID_WIDTH-1:0]     sel_ptr;
    logic [NB_CTRLS-1:0]      sel_oh;
    logic [CID_WIDTH-1:0]     sel_idx;
    logic                     sel_valid;
    logic [CID_WIDTH-1:0]     win_idx;
    logic                     grant;

    assign elig        = req_i & en_i;
    assign free        = !slot_q || gnt_i;
    assign rr_mode     = (mode_i == MCHAN_ARB_RR);
    assign quantum_sel = quantum_i[owner_q];
    assign quantum_eff = (quantum_sel == '0) ? QUANTUM_WIDTH'(1) : quantum_sel;
    assign keep        = rr_mode && owner_v_q && elig[owner_q] && (cnt_q < quantum_eff);
    assign sel_ptr     = rr_mode ? ptr_q : '0;

    mchan_rr_prio_sel #(
        .N  (NB_CTRLS),
        .IW (CID_WIDTH)
    ) u_sel (
        .elig      (elig),
        .ptr       (sel_ptr),
        .win_oh    (sel_oh),
        .win_idx   (sel_idx),
        .any_valid (sel_valid)
    );

    assign win_idx = keep ? owner_q : sel_idx;
    // Gated by reset so no requester sees an accept while the slot is held in reset.
    assign grant   = rst_ni && free && sel_valid;

    always_comb begin
        gnt_o = '0;
        if (grant) begin
            gnt_o = keep ? '0 : sel_oh;
            gnt_o[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q    <= 1'b0;
            payload_q <= '0;
            cid_q     <= '0;
        end else if (free) begin
            slot_q <= sel_valid;
            if (sel_valid) begin
                payload_q <= payload_i[win_idx];
                cid_q     <= win_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            owner_v_q <= 1'b0;
        end else if (free) begin
            if (!rr_mode) begin
                owner_v_q <= 1'b0;
            end else if (keep) begin
                cnt_q <= cnt_q + QUANTUM_WIDTH'(1);
            end else if (sel_valid) begin
                owner_q   <= sel_idx;
                cnt_q     <= QUANTUM_WIDTH'(1);
                owner_v_q <= 1'b1;
                ptr_q     <= (int'(sel_idx) == NB_CTRLS - 1) ? '0 : sel_idx + CID_WIDTH'(1);
            end else begin
                owner_v_q <= 1'b0;
            end
        end
    end

    assign req_o     = slot_q;
    assign payload_o = payload_q;
    assign cid_o     = cid_q;
    assign busy_o    = slot_q || (|elig);

endmodule

// File: tb/tb_mchan_trans_arbiter_wq.sv
// Scoreboard bench for mchan_trans_arbiter_wq: a reference arbiter predicts each
// accept, a monitor checks the output slot against the predicted queue.
module tb_mchan_trans_arbiter_wq;

    localparam int N  = 4;
    localparam int PW = 64;
    localparam int QW = 3;
    localparam int CW = 2;

    logic                  clk = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [N-1:0]          req_i = '0;
    logic [N-1:0]          gnt_o;
    logic [N-1:0][PW-1:0]  payload_i = '0;
    logic [N-1:0]          en_i = '1;
    logic                  mode_i = 1'b0;
    logic [N-1:0][QW-1:0]  quantum_i = '0;
    logic                  req_o;
    logic                  gnt_i = 1'b1;
    logic [PW-1:0]         payload_o;
    logic [CW-1:0]         cid_o;
    logic                  busy_o;

    mchan_trans_arbiter_wq #(
        .NB_CTRLS      (N),
        .PAYLOAD_WIDTH (PW),
        .QUANTUM_WIDTH (QW),
        .CID_WIDTH     (CW)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .payload_i (payload_i),
        .en_i      (en_i),
        .mode_i    (mode_i),
        .quantum_i (quantum_i),
        .req_o     (req_o),
        .gnt_i     (gnt_i),
        .payload_o (payload_o),
        .cid_o     (cid_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] p;
        logic [CW-1:0] c;
    } exp_t;

    exp_t q[$];
    int   cid_log[$];
    int   total = 0;
    int   bad = 0;
    bit   m_slot;
    int   m_ptr = 0, m_own = 0, m_cnt = 0;
    bit   m_ov = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented slot with the oldest prediction.
    always @(negedge clk) begin
        m_slot = (q.size() > 0);
        if (!rst_ni) begin
            chk("rst_req_o", 64'(req_o), 0);
            chk("rst_gnt_o", 64'(gnt_o), 0);
            chk("rst_cid_o", 64'(cid_o), 0);
            chk("rst_payload_o", payload_o, 0);
        end else if (q.size() > 0) begin
            chk("slot_valid", 64'(req_o), 1);
            chk("slot_payload", payload_o, q[0].p);
            chk("slot_cid", 64'(cid_o), 64'(q[0].c));
            if (gnt_i) begin
                cid_log.push_back(int'(cid_o));
                void'(q.pop_front());
            end
        end else begin
            chk("slot_empty", 64'(req_o), 0);
        end
    end

    // Reference arbiter, evaluated once per cycle after the monitor.
    always @(negedge clk) begin
        logic [N-1:0] el;
        logic [N-1:0] eg;
        int win, qe, j;
        exp_t e;
        #1;
        if (!rst_ni) begin
            q.delete();
            m_ptr = 0; m_own = 0; m_cnt = 0; m_ov = 0;
        end else begin
            el  = req_i & en_i;
            win = -1;
            chk("busy_o", 64'(busy_o), 64'(m_slot || (el != 0)));
            if (q.size() == 0) begin
                if (mode_i) begin
                    m_ov = 0;
                    for (int i = 0; i < N; i++) if (el[i] && win < 0) win = i;
                end else begin
                    qe = (quantum_i[m_own] == 0) ? 1 : int'(quantum_i[m_own]);
                    if (m_ov && el[m_own] && m_cnt < qe) begin
                        win = m_own;
                        m_cnt++;
                    end else begin
                        m_ov = 0;
                        for (int k = 0; k < N; k++) begin
                            j = (m_ptr + k) % N;
                            if (el[j] && win < 0) win = j;
                        end
                        if (win >= 0) begin
                            m_own = win; m_cnt = 1; m_ov = 1;
                            m_ptr = (win + 1) % N;
                        end
                    end
                end
                if (win >= 0) begin
                    e.p = payload_i[win];
                    e.c = CW'(win);
                    q.push_back(e);
                end
            end
            eg = '0;
            if (win >= 0) eg[win] = 1'b1;
            chk("gnt_o", 64'(gnt_o), 64'(eg));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) payload_i[i] = {$urandom(), $urandom()};
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        cid_log.delete();
    endtask

    task automatic wait_log(input int n, input int budget);
        int b = 0;
        while (cid_log.size() < n && b < budget) begin
            step();
            b++;
        end
        if (cid_log.size() < n) chk("log_timeout", 64'(cid_log.size()), 64'(n));
    endtask

    int exp_rr1[5]  = '{0, 1, 2, 3, 0};
    int exp_wrr[10] = '{0, 0, 0, 1, 2, 3, 3, 0, 0, 0};
    int pulses;
    logic [PW-1:0] hold;

    initial begin
        // Plain round-robin, first grant straight after reset.
        req_i = 4'b1111; en_i = 4'b1111; mode_i = 1'b0; gnt_i = 1'b1;
        for (int i = 0; i < N; i++) quantum_i[i] = 3'd1;
        do_reset();
        @(negedge clk); #3;
        chk("first_gnt", 64'(gnt_o), 64'(4'b0001));
        wait_log(5, 20);
        for (int i = 0; i < 5; i++) chk("rr_seq", 64'(cid_log[i]), 64'(exp_rr1[i]));

        // Weighted quanta ch0=3 ch1=1 ch2=1 ch3=2.
        quantum_i[0] = 3'd3; quantum_i[1] = 3'd1; quantum_i[2] = 3'd1; quantum_i[3] = 3'd2;
        do_reset();
        wait_log(10, 30);
        for (int i = 0; i < 10; i++) chk("wrr_seq", 64'(cid_log[i]), 64'(exp_wrr[i]));

        // Owner drops after its first grant.
        req_i = 4'b1111;
        do_reset();
        step();
        req_i = 4'b1110;
        wait_log(2, 20);
        chk("owner_drop", 64'(cid_log[1]), 1);

        // Fixed priority, then mask ch1, then back to round-robin.
        req_i = 4'b1110; en_i = 4'b1111; mode_i = 1'b1;
        do_reset();
        repeat (4) step();
        en_i = 4'b1101;
        repeat (4) step();
        @(negedge clk); #3;
        chk("fp_masked_cid", 64'(cid_o), 2);
        step();
        mode_i = 1'b0;
        repeat (4) step();

        // Backpressure with two requesters, then reload on release.
        req_i = 4'b0011; en_i = 4'b1111; gnt_i = 1'b0;
        for (int i = 0; i < N; i++) quantum_i[i] = 3'd1;
        do_reset();
        pulses = 0;
        hold = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #3;
            if (|gnt_o) pulses++;
            if (i == 1) hold = payload_o;
            step();
        end
        chk("bp_pulses", 64'(pulses), 1);
        chk("bp_hold", payload_o, hold);
        gnt_i = 1'b1;
        @(negedge clk); #3;
        chk("bp_reload_gnt", 64'(gnt_o), 64'(4'b0010));
        repeat (3) step();

        // Asynchronous reset while the slot is stalled.
        req_i = 4'b1111; gnt_i = 1'b0;
        do_reset();
        step();
        step();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_req_o", 64'(req_o), 0);
        chk("async_cid_o", 64'(cid_o), 0);
        step();
        gnt_i = 1'b1;
        rst_ni = 1'b1;
        cid_log.delete();
        wait_log(1, 10);
        chk("restart_cid", 64'(cid_log[0]), 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            step();
            req_i = N'($urandom());
            en_i  = N'($urandom() | $urandom());
            gnt_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) mode_i = ~mode_i;
            if ($urandom_range(0, 49) == 0)
                for (int i = 0; i < N; i++) quantum_i[i] = QW'($urandom());
        end
        req_i = '0;
        gnt_i = 1'b1;
        repeat (4) step();
        @(negedge clk); #3;
        chk("final_idle", 64'(req_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
